// File: rtl/multi_debounce.sv
// multi_debounce: N_CH independent switch debouncers sharing one sample tick.
// Each raw input is synchronised, then a per-channel 4-state FSM decides when
// the level is trusted. MODE 0 waits for N_STABLE quiet ticks before moving db.
// MODE 1 moves db on the first edge, then locks out further changes for
// N_STABLE ticks.

module multi_debounce_lane #(
  parameter int N_STABLE = 3,
  parameter int MODE     = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  input  logic tick,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(N_STABLE + 1);
  localparam logic [CW-1:0] LAST = CW'(N_STABLE - 1);

  localparam logic [1:0] STABLE0 = 2'd0;
  localparam logic [1:0] WAIT1   = 2'd1;
  localparam logic [1:0] STABLE1 = 2'd2;
  localparam logic [1:0] WAIT0   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last_tick;

  // The final tick of a wait window: the cnt-th tick closes the window.
  assign last_tick = tick && (cnt == LAST);

  generate
    if (MODE == 0) begin : g_delayed
      // Delayed mode: db only changes after s has held for N_STABLE ticks.
      // Any return of s to the old level aborts the wait silently.
      always_ff @(posedge clk) begin
        if (reset) begin
          state <= STABLE0;
          cnt   <= '0;
          db    <= 1'b0;
          rise  <= 1'b0;
          fall  <= 1'b0;
        end else begin
          rise <= 1'b0;
          fall <= 1'b0;
          case (state)
            STABLE0: begin
              if (s) begin
                state <= WAIT1;
                cnt   <= '0;
              end
            end
            WAIT1: begin
              if (!s) begin
                state <= STABLE0;
              end else if (last_tick) begin
                state <= STABLE1;
                db    <= 1'b1;
                rise  <= 1'b1;
              end else if (tick) begin
                cnt <= cnt + 1'b1;
              end
            end
            STABLE1: begin
              if (!s) begin
                state <= WAIT0;
                cnt   <= '0;
              end
            end
            WAIT0: begin
              if (s) begin
                state <= STABLE1;
              end else if (last_tick) begin
                state <= STABLE0;
                db    <= 1'b0;
                fall  <= 1'b1;
              end else if (tick) begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              state <= STABLE0;
              cnt   <= '0;
              db    <= 1'b0;
            end
          endcase
        end
      end
    end else begin : g_early
      // Early mode: db follows the first edge at once, then s is ignored
      // until the lockout ends; the level seen then decides the final state.
      always_ff @(posedge clk) begin
        if (reset) begin
          state <= STABLE0;
          cnt   <= '0;
          db    <= 1'b0;
          rise  <= 1'b0;
          fall  <= 1'b0;
        end else begin
          rise <= 1'b0;
          fall <= 1'b0;
          case (state)
            STABLE0: begin
              if (s) begin
                state <= WAIT1;
                cnt   <= '0;
                db    <= 1'b1;
                rise  <= 1'b1;
              end
            end
            WAIT1: begin
              if (last_tick) begin
                if (s) begin
                  state <= STABLE1;
                end else begin
                  state <= STABLE0;
                  db    <= 1'b0;
                  fall  <= 1'b1;
                end
              end else if (tick) begin
                cnt <= cnt + 1'b1;
              end
            end
            STABLE1: begin
              if (!s) begin
                state <= WAIT0;
                cnt   <= '0;
                db    <= 1'b0;
                fall  <= 1'b1;
              end
            end
            WAIT0: begin
              if (last_tick) begin
                if (!s) begin
                  state <= STABLE0;
                end else begin
                  state <= STABLE1;
                  db    <= 1'b1;
                  rise  <= 1'b1;
                end
              end else if (tick) begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              state <= STABLE0;
              cnt   <= '0;
              db    <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

endmodule

module multi_debounce #(
  parameter int N_CH        = 4,
  parameter int TICK_DIV    = 1_000_000,
  parameter int N_STABLE    = 3,
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            m_tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [N_CH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [N_CH-1:0]                  s;
  logic [TW-1:0]                    tick_cnt;
  logic [TW-1:0]                    tick_nxt;

  // Synchroniser chains: bit 0 samples the raw pin, the top bit is trusted.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sw[i]};
      end
    end
  end

  // Next value of the shared wrapping tick counter.
  always_comb begin
    tick_nxt = tick_cnt + 1'b1;
    if (tick_cnt == TICK_LAST) tick_nxt = '0;
  end

  // Tick counter plus a registered flag that is high while the counter
  // holds its terminal value, so m_tick is glitch free.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      m_tick   <= 1'b0;
    end else begin
      tick_cnt <= tick_nxt;
      m_tick   <= (tick_nxt == TICK_LAST);
    end
  end

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
      assign s[i] = sync_q[i][SYNC_STAGES-1];

      multi_debounce_lane #(
        .N_STABLE (N_STABLE),
        .MODE     (MODE)
      ) u_lane (
        .clk   (clk),
        .reset (reset),
        .s     (s[i]),
        .tick  (m_tick),
        .db    (db[i]),
        .rise  (rise[i]),
        .fall  (fall[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce: two instances (MODE 0 and MODE 1) with
// N_CH=4, TICK_DIV=10, N_STABLE=3, SYNC_STAGES=2. Expected cycle numbers are
// counted in clock edges since the last reset release (variable n).

module tb_multi_debounce;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] sw0 = '0;
  logic [3:0] sw1 = '0;
  logic [3:0] db0, rise0, fall0;
  logic [3:0] db1, rise1, fall1;
  logic       mt0, mt1;

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int pulses;

  always #5 clk = ~clk;

  multi_debounce #(
    .N_CH(4), .TICK_DIV(10), .N_STABLE(3), .MODE(0), .SYNC_STAGES(2)
  ) dut0 (
    .clk(clk), .reset(reset), .sw(sw0),
    .db(db0), .rise(rise0), .fall(fall0), .m_tick(mt0)
  );

  multi_debounce #(
    .N_CH(4), .TICK_DIV(10), .N_STABLE(3), .MODE(1), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .reset(reset), .sw(sw1),
    .db(db1), .rise(rise1), .fall(fall1), .m_tick(mt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  initial begin
    // reset state
    repeat (3) step();
    chk("rst_db0", db0, 0);
    chk("rst_pulse0", {rise0, fall0}, 0);
    chk("rst_mtick", {mt0, mt1}, 0);
    chk("rst_db1", {db1, rise1, fall1}, 0);

    // m_tick: 100 cycles, pulse after edges 9,19,...,99
    reset = 1'b0;
    n = 0;
    pulses = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      chk("mtick_phase", mt0, (n % 10 == 9) ? 1 : 0);
      if (mt0) pulses++;
    end
    chk("mtick_count", pulses, 10);
    chk("idle_db", {db0, db1}, 0);

    // MODE 0 clean press on ch0: s high after edge 102, WAIT1 at 103,
    // ticks counted at edges 110,120,130 -> accept at 130
    sw0[0] = 1'b1;
    while (n < 129) begin
      step();
      chk("m0_press_wait", {db0, rise0, fall0}, 0);
    end
    step();
    chk("m0_press_db", db0, 4'b0001);
    chk("m0_press_rise", rise0, 4'b0001);
    chk("m0_press_fall", fall0, 0);
    step();
    chk("m0_press_rise_1cyc", rise0, 0);
    chk("m0_press_hold", db0, 4'b0001);

    // MODE 0 release on ch0: WAIT0 at 134, accept at 160
    sw0[0] = 1'b0;
    while (n < 159) begin
      step();
      chk("m0_rel_wait", {db0, rise0, fall0}, {4'b0001, 8'h00});
    end
    step();
    chk("m0_rel_db", db0, 0);
    chk("m0_rel_fall", fall0, 4'b0001);
    step();
    chk("m0_rel_fall_1cyc", {rise0, fall0}, 0);

    // MODE 0 bounce on ch1: toggles every 3 cycles for 40, then low
    for (int i = 0; i < 80; i++) begin
      sw0[1] = (i < 40) && ((i / 3) % 2 == 0);
      step();
      chk("m0_bounce", {db0, rise0, fall0}, 0);
    end

    // MODE 0 simultaneous press, all channels: set at n=241, accept at 270
    sw0 = 4'b1111;
    while (n < 269) begin
      step();
      chk("m0_simul_wait", {db0, rise0}, 0);
    end
    step();
    chk("m0_simul_db", db0, 4'b1111);
    chk("m0_simul_rise", rise0, 4'b1111);
    step();
    chk("m0_simul_rise_1cyc", rise0, 0);

    // MODE 1 glitch on ch2: sw high for edges 272..275, s high 273..276;
    // db jumps at 274, lockout ticks at 280,290,300 -> s=0 -> fall at 300
    sw1[2] = 1'b1;
    step();
    step();
    chk("m1_pre", {db1, rise1}, 0);
    step();
    chk("m1_early_db", db1, 4'b0100);
    chk("m1_early_rise", rise1, 4'b0100);
    step();
    chk("m1_rise_1cyc", rise1, 0);
    sw1[2] = 1'b0;
    while (n < 299) begin
      step();
      chk("m1_lockout", {db1, rise1, fall1}, {4'b0100, 8'h00});
    end
    step();
    chk("m1_end_db", db1, 0);
    chk("m1_end_fall", fall1, 4'b0100);
    chk("m1_indep_dut0", db0, 4'b1111);
    step();
    chk("m1_fall_1cyc", {rise1, fall1}, 0);

    // Reset mid-wait on MODE 0 ch0
    sw0 = 4'b0000;
    reset = 1'b1;
    step();
    step();
    chk("rst2_state", {db0, rise0, fall0, db1}, 0);
    chk("rst2_mtick", {mt0, mt1}, 0);
    reset = 1'b0;
    n = 0;
    sw0[0] = 1'b1;
    while (n < 15) begin
      step();
      chk("rstw_wait", {db0, rise0, fall0}, 0);
    end
    reset = 1'b1;
    step();
    chk("rstw_abort", {db0, rise0, fall0}, 0);
    chk("rstw_mtick", mt0, 0);
    reset = 1'b0;
    n = 0;
    // after release: s high after edge 2, WAIT1 at 3, accept at edge 30
    while (n < 29) begin
      step();
      chk("rstw_restart_wait", {db0, rise0, fall0}, 0);
      if (n == 8) chk("rstw_mtick_pre", mt0, 0);
      if (n == 9) chk("rstw_mtick_first", mt0, 1);
    end
    step();
    chk("rstw_accept_db", db0, 4'b0001);
    chk("rstw_accept_rise", rise0, 4'b0001);
    step();
    chk("rstw_rise_1cyc", rise0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
